mano_sequencer: RTL

Parametrised, clocked control sequencer for the basic-computer datapath. It owns the sequence counter, timing decode, the latched opcode/indirect bit, and the run, interrupt and IEN flip-flops. It drives every register, memory, ALU, E-flag and bus-select strobe for the full instruction set: memory-reference, register-reference and I/O instructions, plus an optional interrupt cycle. It sits between IR/flag outputs and the datapath load/increment/clear inputs and replaces the purely combinational decode.

---
 rtl/mano_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mano_sequencer.sv
// Control sequencer for the basic computer: owns SC, timing decode, D/I latch and S/R/IEN flip-flops.
// All strobes are combinational from state and status inputs; the datapath has no backpressure path.
module mano_sequencer #(
    parameter int DW      = 16,
    parameter int SC_W    = 3,
    parameter int HAS_INT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        ir,
    input  logic                 ac_zero,
    input  logic                 ac_sign,
    input  logic                 e_flag,
    input  logic                 dr_zero,
    input  logic                 fgi,
    input  logic                 fgo,
    output logic [2**SC_W-1:0]   t,
    output logic [2:0]           bus_sel,
    output logic                 ar_ld,
    output logic                 ar_inr,
    output logic                 ar_clr,
    output logic                 pc_ld,
    output logic                 pc_inr,
    output logic                 pc_clr,
    output logic                 dr_ld,
    output logic                 dr_inr,
    output logic                 ir_ld,
    output logic                 tr_ld,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 outr_ld,
    output logic                 fgi_clr,
    output logic                 fgo_clr,
    output logic [3:0]           alu_op,
    output logic                 e_clr,
    output logic                 e_cme,
    output logic                 halted
);
    localparam int NT = 2**SC_W;

    localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
                           BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7;
    localparam logic [3:0] ALU_AND = 4'd1, ALU_ADD = 4'd2, ALU_LDDR = 4'd3, ALU_INP = 4'd4,
                           ALU_CMA = 4'd5, ALU_CIR = 4'd6, ALU_CIL = 4'd7, ALU_CLR = 4'd8,
                           ALU_INC = 4'd9;

    logic [SC_W-1:0] sc;
    logic [7:0]      d;
    logic            i, s, r, ien;

    logic t0, t1, t2, t3, t4, t5, t6;
    logic sc_clr, s_clr, ien_set, ien_clr, r_clr, r_set, wrap;

    assign t0 = (sc == SC_W'(0));
    assign t1 = (sc == SC_W'(1));
    assign t2 = (sc == SC_W'(2));
    assign t3 = (sc == SC_W'(3));
    assign t4 = (sc == SC_W'(4));
    assign t5 = (sc == SC_W'(5));
    assign t6 = (sc == SC_W'(6));

    assign t      = {{(NT-1){1'b0}}, 1'b1} << sc;
    assign halted = ~s;

    // Interrupt request is only sampled outside the fetch/interrupt T0-T2 window.
    assign r_set = (HAS_INT != 0) && ien && (fgi | fgo) && !(t0 | t1 | t2);
    assign wrap  = (sc == {SC_W{1'b1}}) && !sc_clr;

    always_comb begin
        bus_sel = BUS_NONE;
        ar_ld = 1'b0;  ar_inr = 1'b0;  ar_clr = 1'b0;
        pc_ld = 1'b0;  pc_inr = 1'b0;  pc_clr = 1'b0;
        dr_ld = 1'b0;  dr_inr = 1'b0;  ir_ld  = 1'b0;  tr_ld = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0;  outr_ld = 1'b0;
        fgi_clr = 1'b0; fgo_clr = 1'b0;
        alu_op = 4'd0; e_clr = 1'b0;   e_cme = 1'b0;
        sc_clr = 1'b0; s_clr = 1'b0;   ien_set = 1'b0; ien_clr = 1'b0; r_clr = 1'b0;

        if (s) begin
            if (!r) begin
                if (t0) begin bus_sel = BUS_PC; ar_ld = 1'b1; end
                if (t1) begin bus_sel = BUS_MEM; mem_rd = 1'b1; ir_ld = 1'b1; pc_inr = 1'b1; end
                if (t2) begin bus_sel = BUS_IR; ar_ld = 1'b1; end
            end else begin
                if (t0) begin ar_clr = 1'b1; bus_sel = BUS_PC; tr_ld = 1'b1; end
                if (t1) begin bus_sel = BUS_TR; mem_wr = 1'b1; pc_clr = 1'b1; end
                if (t2) begin pc_inr = 1'b1; ien_clr = 1'b1; r_clr = 1'b1; sc_clr = 1'b1; end
            end

            if (t3) begin
                if (d[7]) begin
                    sc_clr = 1'b1;
                    if (!i) begin
                        // Lowest-numbered AC micro-op bit takes priority.
                        if      (ir[5])  alu_op = ALU_INC;
                        else if (ir[6])  alu_op = ALU_CIL;
                        else if (ir[7])  alu_op = ALU_CIR;
                        else if (ir[9])  alu_op = ALU_CMA;
                        else if (ir[11]) alu_op = ALU_CLR;
                        e_clr  = ir[10];
                        e_cme  = ir[8];
                        pc_inr = (ir[4] & ~ac_sign) | (ir[3] & ac_sign) |
                                 (ir[2] & ac_zero)  | (ir[1] & ~e_flag);
                        s_clr  = ir[0];
                    end else begin
                        if (ir[11]) begin alu_op = ALU_INP; fgi_clr = 1'b1; end
                        if (ir[10]) begin bus_sel = BUS_AC; outr_ld = 1'b1; fgo_clr = 1'b1; end
                        pc_inr  = (ir[9] & fgi) | (ir[8] & fgo);
                        ien_set = ir[7];
                        ien_clr = ir[6];
                    end
                end else if (i) begin
                    bus_sel = BUS_MEM; mem_rd = 1'b1; ar_ld = 1'b1;
                end
            end

            if (t4) begin
                if (d[0] | d[1] | d[2] | d[6]) begin bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1; end
                if (d[3]) begin bus_sel = BUS_AC; mem_wr = 1'b1; sc_clr = 1'b1; end
                if (d[4]) begin bus_sel = BUS_AR; pc_ld = 1'b1; sc_clr = 1'b1; end
                if (d[5]) begin bus_sel = BUS_PC; mem_wr = 1'b1; ar_inr = 1'b1; end
            end

            if (t5) begin
                if (d[0]) begin alu_op = ALU_AND;  sc_clr = 1'b1; end
                if (d[1]) begin alu_op = ALU_ADD;  sc_clr = 1'b1; end
                if (d[2]) begin alu_op = ALU_LDDR; sc_clr = 1'b1; end
                if (d[5]) begin bus_sel = BUS_AR; pc_ld = 1'b1; sc_clr = 1'b1; end
                if (d[6]) dr_inr = 1'b1;
            end

            if (t6 && d[6]) begin
                bus_sel = BUS_DR; mem_wr = 1'b1; pc_inr = dr_zero; sc_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc  <= '0;
            d   <= 8'd0;
            i   <= 1'b0;
            s   <= 1'b1;
            r   <= 1'b0;
            ien <= 1'b0;
        end else if (s) begin
            sc <= sc_clr ? '0 : sc + {{(SC_W-1){1'b0}}, 1'b1};
            // A wrap means the flow ran off the end; drop the decode so nothing fires.
            if (wrap) begin
                d <= 8'd0;
                i <= 1'b0;
            end else if (!r && t2) begin
                d <= 8'd1 << ir[DW-2:DW-4];
                i <= ir[DW-1];
            end
            if (s_clr) s <= 1'b0;
            if (HAS_INT != 0) begin
                if (r_clr)      r <= 1'b0;
                else if (r_set) r <= 1'b1;
                if (ien_clr)      ien <= 1'b0;
                else if (ien_set) ien <= 1'b1;
            end
        end
    end
endmodule
